// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display scheduler: blank code, byte order, FSM states.
// SSD_SCHED_BLANK_EN adds the one-cycle BLANK state between owners.
package ssd_pkg;

    localparam logic [7:0] SSD_BLANK = 8'hFF;

    // Byte position of each digit inside a client's 32-bit payload (byte 0 = rightmost digit).
    localparam int DIGIT1_BYTE = 0;
    localparam int DIGIT2_BYTE = 1;
    localparam int DIGIT3_BYTE = 2;
    localparam int DIGIT4_BYTE = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SHOW  = 2'd2
`ifdef SSD_SCHED_BLANK_EN
        , ST_BLANK = 2'd3
`endif
    } sched_state_e;

endpackage

// File: rtl/ssd_rr_arbiter.sv
// Combinational round-robin pick: search starts at ptr+1, wraps modulo NUM_REQ, ptr itself is checked last.
module ssd_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [2:0]         winner,
    output logic               any_req
);

    logic [7:0] req_ext;
    int         idx;

    assign req_ext = 8'(req);

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any_req && req_ext[idx[2:0]]) begin
                any_req = 1'b1;
                winner  = idx[2:0];
            end
        end
    end

endmodule

// File: rtl/ssd_display_sched.sv
// Round-robin time-sharing of the four-digit display with a minimum hold per owner.
// Define SSD_SCHED_BLANK_EN to insert one blank cycle between owners on a switch.
module ssd_display_sched
    import ssd_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [2:0]             owner,
    output logic                   owner_valid,
    output logic [7:0]             digit1,
    output logic [7:0]             digit2,
    output logic [7:0]             digit3,
    output logic [7:0]             digit4,
    output logic [1:0]             state_dbg
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    sched_state_e      state_q, state_d;
    logic [2:0]        ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        owner_q;
    logic              owner_valid_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [31:0]       disp_q;

    logic [2:0]  win_idx;
    logic        win_any;
    logic [7:0]  req_ext, owner_oh, win_oh;
    logic        owner_req, other_req;
    logic        grant, blank, live;
    logic [31:0] payload [8];

    for (genvar g = 0; g < 8; g++) begin : g_pay
        if (g < NUM_REQ) begin : g_used
            assign payload[g] = req_data[32*g +: 32];
        end else begin : g_pad
            assign payload[g] = '0;
        end
    end

    assign req_ext   = 8'(req);
    assign owner_oh  = 8'b1 << owner_q;
    assign win_oh    = 8'b1 << win_idx;
    assign owner_req = req_ext[owner_q];
    assign other_req = |(req_ext & ~owner_oh);

    ssd_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (win_idx),
        .any_req (win_any)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_any) state_d = ST_HOLD;
            ST_HOLD: if (cnt_q == '0) state_d = ST_SHOW;
            ST_SHOW: begin
                if (other_req) begin
`ifdef SSD_SCHED_BLANK_EN
                    state_d = ST_BLANK;
`else
                    state_d = ST_HOLD;
`endif
                end else if (!owner_req) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef SSD_SCHED_BLANK_EN
            ST_BLANK: state_d = win_any ? ST_HOLD : ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Every entry into HOLD is a fresh grant; IDLE/BLANK targets blank the display.
    always_comb begin
        grant = (state_d == ST_HOLD) && (state_q != ST_HOLD);
`ifdef SSD_SCHED_BLANK_EN
        blank = (state_d == ST_IDLE) || (state_d == ST_BLANK);
`else
        blank = (state_d == ST_IDLE);
`endif
        live  = owner_req && !grant && !blank &&
                ((state_q == ST_HOLD) || (state_q == ST_SHOW));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= 3'(NUM_REQ - 1);
            cnt_q         <= '0;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            ack_q         <= '0;
            disp_q        <= {4{SSD_BLANK}};
        end else begin
            ack_q <= '0;
            if (state_q == ST_HOLD && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            if (grant) begin
                ptr_q         <= win_idx;
                cnt_q         <= CNT_LOAD;
                owner_q       <= win_idx;
                owner_valid_q <= 1'b1;
                ack_q         <= win_oh[NUM_REQ-1:0];
                disp_q        <= payload[win_idx];
            end else if (blank) begin
                owner_valid_q <= 1'b0;
                disp_q        <= {4{SSD_BLANK}};
            end else if (live) begin
                disp_q        <= payload[owner_q];
            end
        end
    end

    assign ack         = ack_q;
    assign owner       = owner_q;
    assign owner_valid = owner_valid_q;
    assign digit1      = disp_q[8*DIGIT1_BYTE +: 8];
    assign digit2      = disp_q[8*DIGIT2_BYTE +: 8];
    assign digit3      = disp_q[8*DIGIT3_BYTE +: 8];
    assign digit4      = disp_q[8*DIGIT4_BYTE +: 8];
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ssd_display_sched.sv
// Directed bench for ssd_display_sched: one instance with HOLD_CYCLES=4, one with HOLD_CYCLES=1.
module tb_ssd_display_sched;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;

    logic clk, rst;

    logic [3:0]   req_a, ack_a;
    logic [127:0] req_data_a;
    logic [2:0]   owner_a;
    logic         owner_valid_a;
    logic [7:0]   d1_a, d2_a, d3_a, d4_a;
    logic [1:0]   state_a;

    logic [3:0]   req_b, ack_b;
    logic [127:0] req_data_b;
    logic [2:0]   owner_b;
    logic         owner_valid_b;
    logic [7:0]   d1_b, d2_b, d3_b, d4_b;
    logic [1:0]   state_b;

    int total = 0;
    int bad   = 0;

    ssd_display_sched #(.NUM_REQ(4), .HOLD_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_data(req_data_a), .ack(ack_a),
        .owner(owner_a), .owner_valid(owner_valid_a),
        .digit1(d1_a), .digit2(d2_a), .digit3(d3_a), .digit4(d4_a), .state_dbg(state_a)
    );

    ssd_display_sched #(.NUM_REQ(4), .HOLD_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_data(req_data_b), .ack(ack_b),
        .owner(owner_b), .owner_valid(owner_valid_b),
        .digit1(d1_b), .digit2(d2_b), .digit3(d3_b), .digit4(d4_b), .state_dbg(state_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_data_a(input int c, input logic [31:0] v);
        req_data_a[32*c +: 32] = v;
    endtask

    // checker
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; req_a = '0; req_b = '0; req_data_a = '0; req_data_b = '0;
        steps(2);
        rst = 1'b0;

        chk("rst_state", 32'(state_a), 32'(S_IDLE));
        chk("rst_digit1", 32'(d1_a), 32'hFF);
        chk("rst_digit4", 32'(d4_a), 32'hFF);
        chk("rst_ack", 32'(ack_a), 0);
        chk("rst_valid", 32'(owner_valid_a), 0);
        chk("rst_owner", 32'(owner_a), 0);

        // first grant from IDLE
        set_data_a(0, 32'hC0F9A4B0);
        req_a = 4'b0001;
        step();
        chk("g0_ack", 32'(ack_a), 32'b0001);
        chk("g0_d1", 32'(d1_a), 32'hB0);
        chk("g0_d2", 32'(d2_a), 32'hA4);
        chk("g0_d3", 32'(d3_a), 32'hF9);
        chk("g0_d4", 32'(d4_a), 32'hC0);
        chk("g0_owner", 32'(owner_a), 0);
        chk("g0_valid", 32'(owner_valid_a), 1);

        // competing request during hold: no early switch, live update of owner 0
        req_a = 4'b0011;
        set_data_a(1, 32'h99B0A4F9);
        step();
        chk("hold1_ack", 32'(ack_a), 0);
        chk("hold1_owner", 32'(owner_a), 0);
        chk("hold1_state", 32'(state_a), 32'(S_HOLD));
        set_data_a(0, 32'h11223344);
        step();
        chk("hold_live_d1", 32'(d1_a), 32'h44);
        chk("hold_live_d4", 32'(d4_a), 32'h11);
        steps(2);
        chk("show_state", 32'(state_a), 32'(S_SHOW));
        chk("show_owner", 32'(owner_a), 0);
        chk("show_ack", 32'(ack_a), 0);
        step();
`ifdef SSD_SCHED_BLANK_EN
        chk("sw1_blank_valid", 32'(owner_valid_a), 0);
        chk("sw1_blank_d1", 32'(d1_a), 32'hFF);
        chk("sw1_blank_ack", 32'(ack_a), 0);
        step();
`endif
        chk("sw1_ack", 32'(ack_a), 32'b0010);
        chk("sw1_owner", 32'(owner_a), 1);
        chk("sw1_d1", 32'(d1_a), 32'hF9);
        chk("sw1_d4", 32'(d4_a), 32'h99);

        // owner 1 releases during hold: display frozen, no early release
        req_a = 4'b0100;
        set_data_a(1, 32'hDEADBEEF);
        set_data_a(2, 32'h88898A8B);
        step();
        chk("frz_ack", 32'(ack_a), 0);
        chk("frz_d1", 32'(d1_a), 32'hF9);
        chk("frz_owner", 32'(owner_a), 1);
        steps(3);
        chk("frz_show", 32'(state_a), 32'(S_SHOW));
        chk("frz_show_d1", 32'(d1_a), 32'hF9);
        step();
`ifdef SSD_SCHED_BLANK_EN
        chk("sw2_blank_valid", 32'(owner_valid_a), 0);
        step();
`endif
        chk("sw2_ack", 32'(ack_a), 32'b0100);
        chk("sw2_owner", 32'(owner_a), 2);
        chk("sw2_d1", 32'(d1_a), 32'h8B);

        // owner 2 drops in SHOW with no other requester
        steps(4);
        chk("o2_show", 32'(state_a), 32'(S_SHOW));
        req_a = 4'b0000;
        step();
        chk("drop_state", 32'(state_a), 32'(S_IDLE));
        chk("drop_valid", 32'(owner_valid_a), 0);
        chk("drop_d1", 32'(d1_a), 32'hFF);
        chk("drop_d2", 32'(d2_a), 32'hFF);
        chk("drop_d3", 32'(d3_a), 32'hFF);
        chk("drop_d4", 32'(d4_a), 32'hFF);

        // reset mid-HOLD
        req_a = 4'b0001;
        step();
        chk("pre_rst_ack", 32'(ack_a), 32'b0001);
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_state", 32'(state_a), 32'(S_IDLE));
        chk("mid_rst_d1", 32'(d1_a), 32'hFF);
        chk("mid_rst_ack", 32'(ack_a), 0);
        chk("mid_rst_valid", 32'(owner_valid_a), 0);
        rst = 1'b0;
        req_a = 4'b0110;
        step();
        chk("post_rst_ack", 32'(ack_a), 32'b0010);
        chk("post_rst_owner", 32'(owner_a), 1);

        // switch 0 -> 3
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_data_a(3, 32'h12345678);
        req_a = 4'b0001;
        step();
        chk("s03_ack0", 32'(ack_a), 32'b0001);
        steps(4);
        chk("s03_show", 32'(state_a), 32'(S_SHOW));
        req_a = 4'b1001;
        step();
`ifdef SSD_SCHED_BLANK_EN
        chk("s03_blank_valid", 32'(owner_valid_a), 0);
        chk("s03_blank_d1", 32'(d1_a), 32'hFF);
        chk("s03_blank_d4", 32'(d4_a), 32'hFF);
        chk("s03_blank_ack", 32'(ack_a), 0);
        step();
`endif
        chk("s03_ack3", 32'(ack_a), 32'b1000);
        chk("s03_owner", 32'(owner_a), 3);
        chk("s03_d1", 32'(d1_a), 32'h78);
        req_a = 4'b0000;

        // round robin with HOLD_CYCLES=1 on dut_b
        for (int c = 0; c < 4; c++) req_data_b[32*c +: 32] = {4{8'(8'h10 + c)}};
        req_b = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (ack_b == 4'b0 && n < 4) begin
                step();
                n++;
            end
            chk("rr_wait", (n < 4) ? 1 : 0, 1);
            chk("rr_ack", 32'(ack_b), 32'(4'b1 << (g % 4)));
            chk("rr_owner", 32'(owner_b), 32'(g % 4));
            chk("rr_d1", 32'(d1_b), 32'(8'h10 + (g % 4)));
            step();
            chk("rr_single", 32'(ack_b), 0);
        end
        req_b = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssd_display_sched.md
# ssd_display_sched

Time-shares the four-digit seven-segment display between up to NUM_REQ client blocks, such as the score, timer and message units. It grants the display to one requester at a time in round-robin order and enforces a minimum on-screen hold time. It latches the owner's four segment bytes into the digit1..digit4 inputs of the display scan driver. It sits between the game-logic clients and the scan driver.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2–8.
- HOLD_CYCLES, 50_000_000: minimum number of clk cycles a granted owner stays displayed; must be ≥1.
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  level request; bit i high means client i wants the display.
- req_data  input  32*NUM_REQ  segment payload; slice [32i+31:32i] belongs to client i; byte 0 is the rightmost digit.
- ack  output  NUM_REQ  one-cycle grant pulse to the newly granted client.
- owner  output  3  index of the current owner; valid only when owner_valid=1.
- owner_valid  output  1  high while a client owns the display.
- digit1, digit2, digit3, digit4  output  8 each  segment bytes to the scan driver, active-low; digit1 is the rightmost.

## Operation
- States: IDLE, HOLD, SHOW, plus BLANK when SSD_SCHED_BLANK_EN is defined.
- Reset values:
  - State is IDLE.
  - All digits are 8'hFF (blank).
  - ack=0, owner_valid=0, owner=0.
  - The round-robin pointer is NUM_REQ-1, so client 0 wins first.
- Arbitration: search starts at pointer+1 and wraps modulo NUM_REQ. The current owner is the last candidate checked. The pointer updates to the winner on every grant.
- IDLE:
  - If any req bit is high, grant the winner.
  - Next state is HOLD and the hold counter loads HOLD_CYCLES-1.
  - If no req bit is high, the digits stay 8'hFF.
- Grant actions, all registered on the same edge:
  - digitN takes the winner's bytes.
  - owner takes the winner index and owner_valid goes to 1.
  - ack[winner] is high for exactly one cycle.
- HOLD:
  - The counter decrements by 1 each cycle and moves to SHOW when it reaches 0.
  - While req[owner]=1, the digits re-latch req_data[owner] every cycle (live update).
  - If req[owner]=0, the last value is frozen. The owner is not released before the hold expires.
- SHOW:
  - If any other client requests, switch: with BLANK disabled, re-grant immediately; with BLANK enabled, go to BLANK.
  - If no other client requests and req[owner]=1, stay in SHOW with live update.
  - If no client requests at all, go to IDLE: digits=8'hFF, owner_valid=0.
- Simultaneous events: a new request and the owner's release on the same cycle is treated as a switch. A request arriving in the same cycle the hold expires is evaluated in SHOW on the next cycle.
- Reset mid-operation returns every output to its reset value on the next edge. No ack is issued on that edge.

## Timing
- Request-to-display latency: 1 cycle from IDLE. A req high at edge t gives ack, digits and owner valid after edge t.
- Minimum residency is HOLD_CYCLES+1 cycles: the HOLD cycles plus at least one SHOW cycle before a switch.
- Switch latency in SHOW: 1 cycle with BLANK disabled, 2 cycles with BLANK enabled.
- ack is never high for two consecutive cycles.
- ack is never high for a client whose req was low at the granting edge.
- The hold counter is $clog2(HOLD_CYCLES) bits wide, with a minimum of 1, and has no wrap-around. A value of 0 in HOLD always means "expire".

## Configuration
- SSD_SCHED_BLANK_EN defined:
  - A SHOW→BLANK→grant path is added.
  - BLANK lasts exactly one cycle with digits=8'hFF and owner_valid=0.
  - Arbitration is re-run at the end of BLANK using the current req.
  - If no client requests at that point, next state is IDLE.
- SSD_SCHED_BLANK_EN undefined: the BLANK state does not exist and switches are direct.

## Structure
- Shared package ssd_pkg contains:
  - SSD_BLANK = 8'hFF.
  - The state enum.
  - The payload byte-order constants.
- Sub-module ssd_rr_arbiter: combinational round-robin pick from (req, pointer). It returns a winner index and an any-request flag, and is reusable by other shared-resource controllers.

## Test plan
- Reset, then req=4'b0001 with req_data[31:0]=32'hC0F9A4B0:
  - Next cycle: ack=4'b0001, digit1=8'hB0, digit4=8'hC0, owner=0.
- HOLD_CYCLES=4, owner 0 holding, req=4'b0011 asserted in the hold's first cycle:
  - No switch during HOLD.
  - Switch to owner 1 exactly 5 cycles after the original grant (BLANK disabled).
- req=4'b1111 held with HOLD_CYCLES=1: grants go in order 0,1,2,3,0, each with a single ack pulse.
- Owner 2 drops req in SHOW and no other client requests: next cycle owner_valid=0 and all digits=8'hFF.
- Reset asserted mid-HOLD: next cycle the state is IDLE, digits=8'hFF and ack=0. After reset, req=4'b0110 grants client 1.
- With SSD_SCHED_BLANK_EN, switch from 0 to 3: exactly one cycle of digits=8'hFF with owner_valid=0, then ack=4'b1000.
